// File: rtl/serial_mult_ctrl.sv
// Shift-and-add multiplier; done pulses MULTIPLIER_WID cycles after the accepting edge.
// start is accepted only while ready (IDLE/DONE); requests during RUN are dropped, not queued.
module serial_mult_ctrl #(
  parameter int MULTIPLICAND_WID = 32,
  parameter int MULTIPLIER_WID   = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [MULTIPLICAND_WID-1:0]                M,
  input  logic [MULTIPLIER_WID-1:0]                  Q,
  output logic                                       ready,
  output logic                                       busy,
  output logic                                       done,
  output logic [MULTIPLICAND_WID+MULTIPLIER_WID-1:0] product
);

  localparam int MW = MULTIPLICAND_WID;
  localparam int QW = MULTIPLIER_WID;
  localparam int CW = $clog2(QW) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            load;
  logic            step;
  logic            finish;
  logic [MW-1:0]   mcand_r;
  logic [MW:0]     acc_hi;
  logic [QW-1:0]   acc_lo;
  logic [CW-1:0]   cnt;
  logic [MW:0]     sum;

  // acc_hi keeps one spare bit so the add never loses its carry
  assign sum = acc_lo[0] ? (acc_hi + {1'b0, mcand_r}) : acc_hi;

  // Status outputs decode the state register only, so inputs never reach them combinationally
  assign ready = (state != RUN);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      mcand_r <= M;
      acc_hi  <= '0;
      acc_lo  <= Q;
      cnt     <= '0;
    end else if (step) begin
      acc_hi <= {1'b0, sum[MW:1]};
      acc_lo <= {sum[0], acc_lo[QW-1:1]};
      cnt    <= cnt + CW'(1);
      if (finish) begin
        product <= {sum, acc_lo[QW-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Directed bench for serial_mult_ctrl: latency, hold, back-to-back, ignored starts, async reset.
module tb_serial_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] M;
  logic [31:0] Q;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  serial_mult_ctrl #(
    .MULTIPLICAND_WID(32),
    .MULTIPLIER_WID  (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .M      (M),
    .Q      (Q),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present an op at a negedge; the following posedge accepts it.
  task automatic accept(input string tag, input logic [31:0] m, input logic [31:0] q);
    start = 1'b1;
    M     = m;
    Q     = q;
    @(negedge clk);
    chk_eq({tag, ".ready_lo"}, 64'(ready), 64'd0);
    chk_eq({tag, ".busy_hi"}, 64'(busy), 64'd1);
  endtask

  // Runs from the negedge just after acceptance until done; pokes start at cycles p1/p2.
  task automatic wait_done(input string tag, input logic [63:0] exp_prod,
                           input logic [63:0] held_prod, input bit keep_start,
                           input int p1, input int p2);
    int n      = 0;
    int busy_n = 0;
    bit held   = 1'b1;
    while (!done && n < 200) begin
      if (n == p1 || n == p2) begin
        start = 1'b1;
        M     = 32'd7;
        Q     = 32'd7;
      end else if (!keep_start) begin
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (product !== held_prod) held = 1'b0;
      @(negedge clk);
      n++;
    end
    chk_eq({tag, ".latency"}, 64'(n), 64'd32);
    chk_eq({tag, ".busy_cycles"}, 64'(busy_n), 64'd32);
    chk_eq({tag, ".held_in_run"}, 64'(held), 64'd1);
    chk_eq({tag, ".product"}, product, exp_prod);
    chk_eq({tag, ".busy_lo"}, 64'(busy), 64'd0);
    chk_eq({tag, ".ready_hi"}, 64'(ready), 64'd1);
  endtask

  // One idle cycle after done: pulse must drop, product must hold.
  task automatic after_done(input string tag, input logic [63:0] exp_prod);
    start = 1'b0;
    @(negedge clk);
    chk_eq({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk_eq({tag, ".prod_hold"}, product, exp_prod);
    chk_eq({tag, ".idle_ready"}, 64'(ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input logic [63:0] exp_prod, input logic [63:0] held_prod);
    accept(tag, m, q);
    wait_done(tag, exp_prod, held_prod, 1'b0, -1, -1);
    after_done(tag, exp_prod);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_done;
    rst   = 1'b1;
    start = 1'b0;
    M     = '0;
    Q     = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst.ready", 64'(ready), 64'd1);
    chk_eq("rst.busy", 64'(busy), 64'd0);
    chk_eq("rst.done", 64'(done), 64'd0);
    chk_eq("rst.product", product, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("op6x2", 32'd6, 32'd2, 64'd12, 64'd0);

    // Back-to-back: start rises in the DONE cycle and stays high through the second op
    accept("b2b1", 32'd16, 32'd23);
    wait_done("b2b1", 64'd368, 64'd12, 1'b0, -1, -1);
    chk_eq("b2b1.done_hi", 64'(done), 64'd1);
    start = 1'b1;
    M     = 32'd13;
    Q     = 32'd12;
    @(negedge clk);
    chk_eq("b2b2.done_drop", 64'(done), 64'd0);
    chk_eq("b2b2.no_idle", 64'(busy), 64'd1);
    chk_eq("b2b2.ready_lo", 64'(ready), 64'd0);
    wait_done("b2b2", 64'd156, 64'd368, 1'b1, -1, -1);
    chk_eq("b2b2.done_hi", 64'(done), 64'd1);
    after_done("b2b2", 64'd156);

    run_op("zeroM", 32'd0, 32'h1234_5678, 64'd0, 64'd156);
    run_op("zeroQ", 32'h89AB_CDEF, 32'd0, 64'd0, 64'd0);
    run_op("maxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 64'd0);

    accept("ignore", 32'd16, 32'd16);
    wait_done("ignore", 64'd256, 64'hFFFF_FFFE_0000_0001, 1'b0, 5, 10);
    after_done("ignore", 64'd256);

    // Async reset at iteration 10, between edges
    accept("abort", 32'd3, 32'd5);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_eq("abort.ready", 64'(ready), 64'd1);
    chk_eq("abort.busy", 64'(busy), 64'd0);
    chk_eq("abort.done", 64'(done), 64'd0);
    chk_eq("abort.product", product, 64'd0);
    seen_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk_eq("abort.no_done", 64'(seen_done), 64'd0);
    run_op("post_rst", 32'd3, 32'd5, 64'd15, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
